img_template_match: RTL and testbench

- Parametrised, run-time-loadable successor to the fixed 16x16 image-search lookup.
- Takes the camera pixel stream (X, Y, pixel, valid) and maps each coordinate onto a TW x TH template held in writable RAM, with each template cell covering 2^SHIFT x 2^SHIFT pixels.
- Outputs the template value per pixel and accumulates the per-frame sum of absolute differences (SAD) between camera pixels and template, for downstream detection logic.

---
 rtl/img_template_match.sv | 176 +++++++++++++++++
 tb/tb_img_template_match.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/img_template_match.sv
// Streams camera pixels against a run-time loadable TW x TH template and scores each armed frame by SAD.
// Define IMG_TM_THRESH_EN to add the iTHRESH input and the registered oMATCH output.
module img_template_match #(
    parameter int TW    = 16,
    parameter int TH    = 16,
    parameter int SHIFT = 4,
    parameter int DW    = 10,
    parameter int ACC_W = 32,
    localparam int AW   = $clog2(TW * TH)
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iWR_EN,
    input  logic [AW-1:0]    iWR_ADDR,
    input  logic [DW-1:0]    iWR_DATA,
    input  logic             iDVAL,
    input  logic [12:0]      iX,
    input  logic [12:0]      iY,
    input  logic [DW-1:0]    iPIX,
    input  logic             iSOF,
    input  logic             iEOF,
    input  logic             iSTART,
`ifdef IMG_TM_THRESH_EN
    input  logic [ACC_W-1:0] iTHRESH,
    output logic             oMATCH,
`endif
    output logic [DW-1:0]    oVAL,
    output logic             oVAL_DVAL,
    output logic             oIN_WIN,
    output logic [ACC_W-1:0] oSCORE,
    output logic             oDONE,
    output logic             oBUSY
);

    // state    | meaning
    // IDLE     | no measurement armed
    // WAIT_SOF | armed, waiting for the next start of frame
    // ACCUM    | summing |pixel - template| over in-window pixels
    // DRAIN    | frame ended, pixels still in the pipeline are summed
    // DONE     | publish score, pulse oDONE
    typedef enum logic [2:0] {IDLE, WAIT_SOF, ACCUM, DRAIN, DONE} tmState;

    localparam logic [13:0] TW_L  = 14'(TW);
    localparam logic [13:0] TH_L  = 14'(TH);
    localparam logic [31:0] TW_32 = 32'(TW);

    tmState           state;
    logic [1:0]       drainCnt;
    logic [ACC_W-1:0] acc;

    logic [12:0]   cx, cy;
    logic          inWin, sofAccept;
    logic          s1Val, s1Win, s1Cnt;
    logic [12:0]   s1Cx, s1Cy;
    logic [DW-1:0] s1Pix;
    logic          s2Val, s2Win, s2Cnt;
    logic [AW-1:0] s2Addr;
    logic [DW-1:0] s2Pix;
    logic          s3Cnt;
    logic [DW-1:0] s3Pix;

    logic [DW-1:0]    absDiff;
    logic [ACC_W:0]   accSum;
    logic [ACC_W-1:0] accNext;

    logic [DW-1:0] tplRam [TW*TH];

    assign cx        = iX >> SHIFT;
    assign cy        = iY >> SHIFT;
    assign inWin     = ({1'b0, cx} < TW_L) && ({1'b0, cy} < TH_L);
    assign sofAccept = iSOF && (state == WAIT_SOF || state == ACCUM);

    always_ff @(posedge iCLK) begin
        if (iWR_EN) tplRam[iWR_ADDR] <= iWR_DATA;
    end

    // sXCnt marks pixels belonging to the current measurement; an accepted SOF drops older ones in flight
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            s1Val     <= 1'b0;
            s1Win     <= 1'b0;
            s1Cnt     <= 1'b0;
            s1Cx      <= '0;
            s1Cy      <= '0;
            s1Pix     <= '0;
            s2Val     <= 1'b0;
            s2Win     <= 1'b0;
            s2Cnt     <= 1'b0;
            s2Addr    <= '0;
            s2Pix     <= '0;
            s3Cnt     <= 1'b0;
            s3Pix     <= '0;
            oVAL      <= '0;
            oVAL_DVAL <= 1'b0;
            oIN_WIN   <= 1'b0;
        end else begin
            s1Val     <= iDVAL;
            s1Win     <= inWin;
            s1Cnt     <= iDVAL && inWin && (state == ACCUM || sofAccept);
            s1Cx      <= cx;
            s1Cy      <= cy;
            s1Pix     <= iPIX;
            s2Val     <= s1Val;
            s2Win     <= s1Win;
            s2Cnt     <= s1Cnt && !sofAccept;
            s2Addr    <= AW'(32'(s1Cy) * TW_32 + 32'(s1Cx));
            s2Pix     <= s1Pix;
            s3Cnt     <= s2Cnt && !sofAccept;
            s3Pix     <= s2Pix;
            oVAL      <= s2Win ? tplRam[s2Addr] : '0;
            oVAL_DVAL <= s2Val;
            oIN_WIN   <= s2Win && s2Val;
        end
    end

    assign absDiff = (s3Pix >= oVAL) ? (s3Pix - oVAL) : (oVAL - s3Pix);
    assign accSum  = {1'b0, acc} + {{(ACC_W + 1 - DW){1'b0}}, absDiff};
    assign accNext = accSum[ACC_W] ? '1 : accSum[ACC_W-1:0];

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state    <= IDLE;
            drainCnt <= '0;
            acc      <= '0;
            oSCORE   <= '0;
            oDONE    <= 1'b0;
            oBUSY    <= 1'b0;
`ifdef IMG_TM_THRESH_EN
            oMATCH   <= 1'b0;
`endif
        end else begin
            oDONE <= 1'b0;
            if (s3Cnt && (state == ACCUM || state == DRAIN)) acc <= accNext;
            unique case (state)
                IDLE: begin
                    if (iSTART) begin
                        state <= WAIT_SOF;
                        oBUSY <= 1'b1;
                    end
                end
                WAIT_SOF: begin
                    if (iSOF) begin
                        state <= ACCUM;
                        acc   <= '0;
                    end
                end
                ACCUM: begin
                    if (iSOF) begin
                        acc <= '0;
                    end else if (iEOF) begin
                        state    <= DRAIN;
                        drainCnt <= 2'd3;
                    end
                end
                DRAIN: begin
                    if (drainCnt == 2'd0) state <= DONE;
                    else drainCnt <= drainCnt - 2'd1;
                end
                DONE: begin
                    oSCORE <= acc;
                    oDONE  <= 1'b1;
                    oBUSY  <= 1'b0;
                    state  <= IDLE;
`ifdef IMG_TM_THRESH_EN
                    oMATCH <= (acc <= iTHRESH);
`endif
                end
                default: begin
                    state <= IDLE;
                    oBUSY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_img_template_match.sv
`timescale 1ns/1ps
// Bench for img_template_match: random pixel streams and frames checked against a coordinate-level model;
// a second instance with a 16-bit score exercises saturation.
module tb_img_template_match;
    localparam int TW    = 16;
    localparam int TH    = 16;
    localparam int SHIFT = 4;
    localparam int DW    = 10;
    localparam int CELL  = 1 << SHIFT;
    localparam int NCELL = TW * TH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wrEn = 1'b0;
    logic [7:0]    wrAddr = '0;
    logic [DW-1:0] wrData = '0;
    logic [DW-1:0] wrDataB = '0;
    logic          dval = 1'b0;
    logic [12:0]   x = '0;
    logic [12:0]   y = '0;
    logic [DW-1:0] pix = '0;
    logic [DW-1:0] pixB = '0;
    logic          sof = 1'b0;
    logic          eof = 1'b0;
    logic          start = 1'b0;

    logic [DW-1:0] valA, valB;
    logic          dvA, dvB, winA, winB, doneA, doneB, busyA, busyB;
    logic [31:0]   scoreA;
    logic [15:0]   scoreB;
`ifdef IMG_TM_THRESH_EN
    logic [31:0]   thresh = '0;
    logic [15:0]   threshB = '0;
    logic          matchA, matchB;
`endif

    int tplA [NCELL];
    int tplB [NCELL];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    img_template_match #(.TW(TW), .TH(TH), .SHIFT(SHIFT), .DW(DW), .ACC_W(32)) dutA (
        .iCLK(clk), .iRST(rst), .iWR_EN(wrEn), .iWR_ADDR(wrAddr), .iWR_DATA(wrData),
        .iDVAL(dval), .iX(x), .iY(y), .iPIX(pix), .iSOF(sof), .iEOF(eof), .iSTART(start),
`ifdef IMG_TM_THRESH_EN
        .iTHRESH(thresh), .oMATCH(matchA),
`endif
        .oVAL(valA), .oVAL_DVAL(dvA), .oIN_WIN(winA), .oSCORE(scoreA), .oDONE(doneA), .oBUSY(busyA)
    );

    img_template_match #(.TW(TW), .TH(TH), .SHIFT(SHIFT), .DW(DW), .ACC_W(16)) dutB (
        .iCLK(clk), .iRST(rst), .iWR_EN(wrEn), .iWR_ADDR(wrAddr), .iWR_DATA(wrDataB),
        .iDVAL(dval), .iX(x), .iY(y), .iPIX(pixB), .iSOF(sof), .iEOF(eof), .iSTART(start),
`ifdef IMG_TM_THRESH_EN
        .iTHRESH(threshB), .oMATCH(matchB),
`endif
        .oVAL(valB), .oVAL_DVAL(dvB), .oIN_WIN(winB), .oSCORE(scoreB), .oDONE(doneB), .oBUSY(busyB)
    );

    // Template cell index of a coordinate, -1 when it falls outside the template window.
    function automatic int cellOf(input int px, input int py);
        int cx = px / CELL;
        int cy = py / CELL;
        if (cx < TW && cy < TH) return cy * TW + cx;
        return -1;
    endfunction

    function automatic int sadOf(input int px, input int py, input int p);
        int a = cellOf(px, py);
        int d;
        if (a < 0) return 0;
        d = p - tplA[a];
        return (d < 0) ? -d : d;
    endfunction

    task automatic writeCell(input int a, input int dA, input int dB);
        @(negedge clk);
        wrEn = 1'b1; wrAddr = 8'(a); wrData = DW'(dA); wrDataB = DW'(dB);
        tplA[a] = dA; tplB[a] = dB;
    endtask

    task automatic writeEnd();
        @(negedge clk);
        wrEn = 1'b0;
    endtask

    task automatic drivePix(input bit v, input int px, input int py, input int p, input int pb);
        dval = v; x = 13'(px); y = 13'(py); pix = DW'(p); pixB = DW'(pb);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (valA !== '0)   begin errors++; $display("FAIL reset_val: got %0d expected 0", valA); end
        checks++; if (dvA !== 1'b0)  begin errors++; $display("FAIL reset_dval: got %0b expected 0", dvA); end
        checks++; if (winA !== 1'b0) begin errors++; $display("FAIL reset_win: got %0b expected 0", winA); end
        checks++; if (scoreA !== '0) begin errors++; $display("FAIL reset_score: got %0d expected 0", scoreA); end
        checks++; if (doneA !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", doneA); end
        checks++; if (busyA !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busyA); end
        checks++; if ({valB, dvB, winB, scoreB, doneB, busyB} !== '0)
            begin errors++; $display("FAIL reset_b: got %0h expected 0", {valB, dvB, winB, scoreB, doneB, busyB}); end
`ifdef IMG_TM_THRESH_EN
        checks++; if ({matchA, matchB} !== 2'b00) begin errors++; $display("FAIL reset_match: got %0b expected 0", {matchA, matchB}); end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_latency();
        writeCell(5, 77, 0);
        writeEnd();
        @(negedge clk);
        drivePix(1'b1, 80, 0, 0, 0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            dval = 1'b0;
            checks++;
            if (dvA !== (c == 3)) begin errors++; $display("FAIL latency_dval@%0d: got %0b expected %0b", c, dvA, (c == 3)); end
            if (c == 3) begin
                checks++; if (valA !== 10'd77) begin errors++; $display("FAIL latency_val: got %0d expected 77", valA); end
                checks++; if (winA !== 1'b1)  begin errors++; $display("FAIL latency_win: got %0b expected 1", winA); end
            end
        end
    endtask

    task automatic test_window_edges();
        int xs [6] = '{255, 256, 0, 8191, 0, 240};
        int ys [6] = '{0, 0, 300, 8191, 255, 17};
        bit eDv [9];
        bit eWin [9];
        int eVal [9];
        int a;
        for (int i = 0; i < NCELL; i++) writeCell(i, $urandom_range(1, 1023), $urandom_range(0, 1023));
        writeEnd();
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k >= 3) begin
                checks++;
                if (dvA !== eDv[k-3]) begin errors++; $display("FAIL win_dval[%0d]: got %0b expected %0b", k - 3, dvA, eDv[k-3]); end
                if (eDv[k-3]) begin
                    checks++; if (winA !== eWin[k-3]) begin errors++; $display("FAIL win_flag[%0d]: got %0b expected %0b", k - 3, winA, eWin[k-3]); end
                    checks++; if (valA !== DW'(eVal[k-3])) begin errors++; $display("FAIL win_val[%0d]: got %0d expected %0d", k - 3, valA, eVal[k-3]); end
                end
            end
            if (k < 6) begin
                drivePix(1'b1, xs[k], ys[k], 0, 0);
                a = cellOf(xs[k], ys[k]);
                eDv[k] = 1'b1; eWin[k] = (a >= 0); eVal[k] = (a >= 0) ? tplA[a] : 0;
            end else begin
                dval = 1'b0; eDv[k] = 1'b0; eWin[k] = 1'b0; eVal[k] = 0;
            end
        end
    endtask

    task automatic test_rw_collision();
        int oldV;
        writeCell(0, 0, 0);
        writeEnd();
        oldV = tplA[0];
        @(negedge clk); drivePix(1'b1, 0, 0, 0, 0);
        @(negedge clk); dval = 1'b0;
        @(negedge clk); wrEn = 1'b1; wrAddr = 8'd0; wrData = 10'd9; wrDataB = 10'd0;
        @(negedge clk);
        wrEn = 1'b0; tplA[0] = 9;
        checks++; if (dvA !== 1'b1) begin errors++; $display("FAIL rw_old_dval: got %0b expected 1", dvA); end
        checks++; if (valA !== DW'(oldV)) begin errors++; $display("FAIL rw_old_val: got %0d expected %0d", valA, oldV); end
        drivePix(1'b1, 0, 0, 0, 0);
        @(negedge clk); dval = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (dvA !== 1'b1) begin errors++; $display("FAIL rw_new_dval: got %0b expected 1", dvA); end
        checks++; if (valA !== DW'(tplA[0])) begin errors++; $display("FAIL rw_new_val: got %0d expected %0d", valA, tplA[0]); end
    endtask

    task automatic test_random_stream();
        bit eDv [303];
        bit eWin [303];
        int eVal [303];
        int a, px, py;
        bit v;
        for (int k = 0; k < 303; k++) begin
            @(negedge clk);
            if (k >= 3) begin
                checks++;
                if (dvA !== eDv[k-3]) begin errors++; $display("FAIL stream_dval[%0d]: got %0b expected %0b", k - 3, dvA, eDv[k-3]); end
                if (eDv[k-3]) begin
                    checks++;
                    if ({winA, valA} !== {eWin[k-3], DW'(eVal[k-3])})
                        begin errors++; $display("FAIL stream_val[%0d]: got win %0b val %0d expected win %0b val %0d", k - 3, winA, valA, eWin[k-3], eVal[k-3]); end
                end
            end
            if (k < 300) begin
                v  = ($urandom_range(0, 3) != 0);
                px = ($urandom_range(0, 15) == 0) ? 8191 : $urandom_range(0, 300);
                py = $urandom_range(0, 300);
                drivePix(v, px, py, $urandom_range(0, 1023), 0);
                a = cellOf(px, py);
                eDv[k] = v; eWin[k] = (a >= 0); eVal[k] = (a >= 0) ? tplA[a] : 0;
            end else begin
                dval = 1'b0; eDv[k] = 1'b0; eWin[k] = 1'b0; eVal[k] = 0;
            end
        end
    endtask

    task automatic test_sad_random();
        longint sum;
        int px, py, p;
        bit v;
        for (int f = 0; f < 2; f++) begin
            @(negedge clk); start = 1'b1;
            @(negedge clk); start = 1'b0;
            @(negedge clk);
            checks++; if (busyA !== 1'b1) begin errors++; $display("FAIL sad_busy[%0d]: got %0b expected 1", f, busyA); end
            sum = 0;
            for (int k = 0; k < 200; k++) begin
                @(negedge clk);
                sof = (k == 0); eof = (k == 199);
                v  = ($urandom_range(0, 3) != 0);
                px = $urandom_range(0, 300); py = $urandom_range(0, 300); p = $urandom_range(0, 1023);
                drivePix(v, px, py, p, 0);
                if (v) sum += sadOf(px, py, p);
            end
`ifdef IMG_TM_THRESH_EN
            thresh = (f == 0 || sum == 0) ? 32'(sum) : 32'(sum - 1);
`endif
            for (int c = 0; c <= 6; c++) begin
                @(negedge clk);
                sof = 1'b0; eof = 1'b0; dval = 1'b0;
                checks++; if (doneA !== (c == 5)) begin errors++; $display("FAIL sad_done@%0d: got %0b expected %0b", c, doneA, (c == 5)); end
                if (c >= 5) begin
                    checks++; if (scoreA !== 32'(sum)) begin errors++; $display("FAIL sad_score[%0d]: got %0d expected %0d", f, scoreA, sum); end
                    checks++; if (busyA !== 1'b0) begin errors++; $display("FAIL sad_idle[%0d]: got %0b expected 0", f, busyA); end
`ifdef IMG_TM_THRESH_EN
                    checks++; if (matchA !== (sum <= longint'(thresh))) begin errors++; $display("FAIL sad_match[%0d]: got %0b expected %0b", f, matchA, (sum <= longint'(thresh))); end
`endif
                end
            end
        end
    endtask

    task automatic test_control();
        int doneCnt, px, py, p;
        longint sum;
        // arm, then a stray EOF while waiting for SOF
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; eof = 1'b1;
        @(negedge clk); eof = 1'b0;
        doneCnt = 0;
        repeat (8) begin @(negedge clk); if (doneA) doneCnt++; end
        checks++; if (doneCnt != 0) begin errors++; $display("FAIL ctl_eof_wait: got %0d done pulses expected 0", doneCnt); end
        checks++; if (busyA !== 1'b1) begin errors++; $display("FAIL ctl_busy_wait: got %0b expected 1", busyA); end
        // SOF and EOF together: measurement starts, EOF is ignored
        @(negedge clk); sof = 1'b1; eof = 1'b1; drivePix(1'b1, 20, 20, 100, 0);
        @(negedge clk); sof = 1'b0; eof = 1'b0; dval = 1'b0;
        doneCnt = 0;
        repeat (8) begin @(negedge clk); if (doneA) doneCnt++; end
        checks++; if (doneCnt != 0) begin errors++; $display("FAIL ctl_sof_eof: got %0d done pulses expected 0", doneCnt); end
        // SOF during ACCUM restarts the sum; a START in the middle is ignored
        sum = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            sof = (k == 0); start = (k == 4); eof = (k == 9);
            px = $urandom_range(0, 300); py = $urandom_range(0, 300); p = $urandom_range(0, 1023);
            drivePix(1'b1, px, py, p, 0);
            sum += sadOf(px, py, p);
        end
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            sof = 1'b0; start = 1'b0; eof = 1'b0; dval = 1'b0;
            checks++; if (doneA !== (c == 5)) begin errors++; $display("FAIL ctl_done@%0d: got %0b expected %0b", c, doneA, (c == 5)); end
        end
        checks++; if (scoreA !== 32'(sum)) begin errors++; $display("FAIL ctl_score: got %0d expected %0d", scoreA, sum); end
        // reset in the middle of a frame
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            sof = (k == 0);
            drivePix(1'b1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1023), 0);
        end
        @(negedge clk);
        sof = 1'b0; dval = 1'b0;
        checks++; if (scoreA !== 32'(sum)) begin errors++; $display("FAIL ctl_score_hold: got %0d expected %0d", scoreA, sum); end
        rst = 1'b1;
        #1;
        checks++; if (busyA !== 1'b0) begin errors++; $display("FAIL ctl_rst_busy: got %0b expected 0", busyA); end
        checks++; if (scoreA !== '0) begin errors++; $display("FAIL ctl_rst_score: got %0d expected 0", scoreA); end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); eof = 1'b1; sof = 1'b1;
        @(negedge clk); eof = 1'b0; sof = 1'b0;
        @(negedge clk);
        checks++; if (busyA !== 1'b0) begin errors++; $display("FAIL ctl_idle_after_rst: got %0b expected 0", busyA); end
    endtask

    task automatic test_full_frame();
        longint sumA, sumB, expB;
        int a, d;
        for (int i = 0; i < NCELL; i++) writeCell(i, (i == 0) ? 0 : 255, 0);
        writeEnd();
`ifdef IMG_TM_THRESH_EN
        thresh = 32'd65280; threshB = 16'd65534;
`endif
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        sumA = 0; sumB = 0;
        for (int py = 0; py < 256; py++) begin
            for (int px = 0; px < 256; px++) begin
                @(negedge clk);
                sof = (px == 0 && py == 0); eof = (px == 255 && py == 255);
                drivePix(1'b1, px, py, 255, 1023);
                sumA += sadOf(px, py, 255);
                a = cellOf(px, py);
                d = 1023 - tplB[a];
                sumB += (d < 0) ? -d : d;
            end
        end
        expB = (sumB > 65535) ? 65535 : sumB;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            sof = 1'b0; eof = 1'b0; dval = 1'b0;
            checks++; if (doneA !== (c == 5)) begin errors++; $display("FAIL full_done@%0d: got %0b expected %0b", c, doneA, (c == 5)); end
            checks++; if (doneB !== (c == 5)) begin errors++; $display("FAIL sat_done@%0d: got %0b expected %0b", c, doneB, (c == 5)); end
        end
        checks++; if (scoreA !== 32'(sumA)) begin errors++; $display("FAIL full_score: got %0d expected %0d", scoreA, sumA); end
        checks++; if (scoreB !== 16'(expB)) begin errors++; $display("FAIL sat_score: got %0d expected %0d", scoreB, expB); end
        checks++; if (busyB !== 1'b0) begin errors++; $display("FAIL sat_idle: got %0b expected 0", busyB); end
`ifdef IMG_TM_THRESH_EN
        checks++; if (matchA !== (sumA <= longint'(thresh))) begin errors++; $display("FAIL full_match: got %0b expected %0b", matchA, (sumA <= longint'(thresh))); end
        checks++; if (matchB !== (expB <= longint'(threshB))) begin errors++; $display("FAIL sat_match: got %0b expected %0b", matchB, (expB <= longint'(threshB))); end
`endif
    endtask

    initial begin
        test_reset();
        test_latency();
        test_window_edges();
        test_rw_collision();
        test_random_stream();
        test_sad_random();
        test_control();
        test_full_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
